mem_initiator: RTL and testbench

//  Bus master for the DLX data/instruction memory interface (mem_interface, initiator side).

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_initiator.sv | 192 +++++++++++++++++++
 tb/tb_mem_initiator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the DLX memory-interface initiator.
// Access sizes, initiator FSM states and the alignment rule.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      TURN  = 3'd4
   } init_state_t;

   // Size 2'b11 has no legal encoding, so it always counts as misaligned.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] addr
   );
      logic r_mis;
      case (size)
         MEM_BYTE: r_mis = 1'b0;
         MEM_HALF: r_mis = addr[0];
         MEM_WORD: r_mis = |addr;
         default:  r_mis = 1'b1;
      endcase
      return r_mis;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Low-lane extraction and sign/zero extension of load data.
// Shared by the data-memory initiator and the fetch path.
module mem_load_align
   import mem_pkg::*;
#(
   parameter int WORD_SIZE = 32
)(
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic [1:0]           i_size,
   input  logic                 i_signed,
   output logic [WORD_SIZE-1:0] o_data
);

   logic w_sb;
   logic w_sh;

   assign w_sb = i_signed & i_data[7];
   assign w_sh = i_signed & i_data[15];

   always_comb begin
      o_data = i_data;
      case (i_size)
         MEM_BYTE: o_data = {{(WORD_SIZE-8){w_sb}}, i_data[7:0]};
         MEM_HALF: o_data = {{(WORD_SIZE-16){w_sh}}, i_data[15:0]};
         default:  o_data = i_data;
      endcase
   end

endmodule

// File: rtl/mem_initiator.sv
// Bus master for the DLX memory interface: one load/store at a time
// over ENABLE/READNOTWRITE/DATA_READY with a shared tri-state data bus.
module mem_initiator
   import mem_pkg::*;
#(
   parameter int WORD_SIZE      = 32,
   parameter int ADDRESS_SIZE   = 16,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]    req_wdata,
   output logic                    rsp_valid,
   output logic                    rsp_err,
   output logic [WORD_SIZE-1:0]    rsp_rdata,
   output logic                    ENABLE,
   output logic                    READNOTWRITE,
   output logic [ADDRESS_SIZE-1:0] ADDRESS,
   inout  wire  [WORD_SIZE-1:0]    INOUT_DATA,
   input  logic                    DATA_READY
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   init_state_t r_state;
   init_state_t w_state_nxt;

   logic                    r_we;
   logic                    w_we_nxt;
   logic [1:0]              r_size;
   logic [1:0]              w_size_nxt;
   logic                    r_signed;
   logic                    w_signed_nxt;
   logic [ADDRESS_SIZE-1:0] r_addr;
   logic [ADDRESS_SIZE-1:0] w_addr_nxt;
   logic [WORD_SIZE-1:0]    r_wdata;
   logic [WORD_SIZE-1:0]    w_wdata_nxt;
   logic                    r_en;
   logic                    w_en_nxt;
   logic                    r_rnw;
   logic                    w_rnw_nxt;
   logic [CW-1:0]           r_cnt;
   logic [CW-1:0]           w_cnt_nxt;
   logic                    r_rsp_valid;
   logic                    w_rsp_valid_nxt;
   logic                    r_rsp_err;
   logic                    w_rsp_err_nxt;
   logic [WORD_SIZE-1:0]    r_rsp_rdata;
   logic [WORD_SIZE-1:0]    w_rsp_rdata_nxt;

   logic [WORD_SIZE-1:0]    w_lanes;
   logic [WORD_SIZE-1:0]    w_ld_data;

   // Store data is lane-formatted at accept time; unused upper lanes are 0.
   always_comb begin
      w_lanes = '0;
      case (req_size)
         MEM_BYTE: w_lanes[7:0]  = req_wdata[7:0];
         MEM_HALF: w_lanes[15:0] = req_wdata[15:0];
         default:  w_lanes       = req_wdata;
      endcase
   end

   mem_load_align #(
      .WORD_SIZE (WORD_SIZE)
   ) u_align (
      .i_data   (INOUT_DATA),
      .i_size   (r_size),
      .i_signed (r_signed),
      .o_data   (w_ld_data)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_we_nxt        = r_we;
      w_size_nxt      = r_size;
      w_signed_nxt    = r_signed;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_en_nxt        = r_en;
      w_rnw_nxt       = r_rnw;
      w_cnt_nxt       = r_cnt;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_rsp_rdata_nxt = '0;
      unique case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_we_nxt     = req_we;
               w_size_nxt   = req_size;
               w_signed_nxt = req_signed;
               w_addr_nxt   = req_addr;
               w_wdata_nxt  = w_lanes;
               w_state_nxt  = CHECK;
            end
         end
         CHECK: begin
            if (is_misaligned(r_size, r_addr[1:0])) begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_state_nxt     = RESP;
            end else begin
               w_en_nxt    = 1'b1;
               w_rnw_nxt   = ~r_we;
               w_cnt_nxt   = '0;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (DATA_READY) begin
               w_en_nxt        = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = r_we ? '0 : w_ld_data;
               w_state_nxt     = RESP;
            end else if (r_cnt == CNT_MAX) begin
               w_en_nxt        = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_state_nxt     = RESP;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         RESP: begin
            // A store needs a turnaround cycle before the bus is reused.
            if (r_we) begin
               w_rnw_nxt   = 1'b1;
               w_state_nxt = TURN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         TURN: begin
            w_rnw_nxt   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_en_nxt    = 1'b0;
            w_rnw_nxt   = 1'b1;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_signed    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_en        <= 1'b0;
         r_rnw       <= 1'b1;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_we        <= w_we_nxt;
         r_size      <= w_size_nxt;
         r_signed    <= w_signed_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_en        <= w_en_nxt;
         r_rnw       <= w_rnw_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   assign INOUT_DATA = (r_en && !r_rnw) ? r_wdata : {WORD_SIZE{1'bz}};

   assign req_ready    = (r_state == IDLE);
   assign rsp_valid    = r_rsp_valid;
   assign rsp_err      = r_rsp_err;
   assign rsp_rdata    = r_rsp_rdata;
   assign ENABLE       = r_en;
   assign READNOTWRITE = r_rnw;
   assign ADDRESS      = r_addr;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a byte-array memory responder
// and a queue-based response model.
module tb_mem_initiator;

   localparam int TO    = 16;
   localparam int DELAY = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid  = 1'b0;
   logic        req_we     = 1'b0;
   logic [1:0]  req_size   = 2'b00;
   logic        req_signed = 1'b0;
   logic [15:0] req_addr   = '0;
   logic [31:0] req_wdata  = '0;
   logic        DATA_READY = 1'b0;
   wire         req_ready;
   wire         rsp_valid;
   wire         rsp_err;
   wire  [31:0] rsp_rdata;
   wire         ENABLE;
   wire         READNOTWRITE;
   wire  [15:0] ADDRESS;
   wire  [31:0] INOUT_DATA;

   mem_initiator #(
      .WORD_SIZE      (32),
      .ADDRESS_SIZE   (16),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .ENABLE       (ENABLE),
      .READNOTWRITE (READNOTWRITE),
      .ADDRESS      (ADDRESS),
      .INOUT_DATA   (INOUT_DATA),
      .DATA_READY   (DATA_READY)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory responder: byte array, DATA_READY DELAY cycles into the access.
   logic [7:0]  mem    [0:65535];
   logic [7:0]  shadow [0:65535];
   logic        stub = 1'b0;
   logic        drv  = 1'b0;
   logic [31:0] rd   = '0;
   logic [1:0]  cur_size = 2'b10;
   int          mcnt = 0;

   assign INOUT_DATA = drv ? rd : 32'bz;

   always @(posedge clk) begin : responder
      int a;
      a = int'(ADDRESS);
      if (!ENABLE || !rst) begin
         DATA_READY <= 1'b0;
         drv        <= 1'b0;
         mcnt       <= 0;
      end else if (!DATA_READY && !stub) begin
         if (mcnt == DELAY - 1) begin
            DATA_READY <= 1'b1;
            if (READNOTWRITE) begin
               drv <= 1'b1;
               rd  <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
            end else begin
               for (int i = 0; i < (1 << cur_size); i++)
                  mem[a+i] <= INOUT_DATA[8*i +: 8];
            end
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end

   // Response model: spec rules over a shadow memory.
   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q[$];
   logic [31:0] exp_bus = '0;
   int          nrsp = 0;

   function automatic exp_t model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [15:0] ad, input logic [31:0] wd, input logic to);
      exp_t        e;
      int          nb;
      logic [31:0] v;
      nb      = 1 << sz;
      e.err   = (sz == 2'd3) || ((int'(ad) % nb) != 0) || to;
      e.rdata = '0;
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < nb; i++) shadow[int'(ad)+i] = wd[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = shadow[int'(ad)+i];
            if (sg && v[8*nb-1])
               for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin : compare
      exp_t e;
      if (rst) begin
         if (rsp_valid) begin
            nrsp++;
            if (q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               chk("rsp_rdata", rsp_rdata, e.rdata);
            end
         end
         if (ENABLE && !READNOTWRITE) chk("bus_wdata", INOUT_DATA, exp_bus);
      end
   end

   logic [31:0] last_rdata;

   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [15:0] ad, input logic [31:0] wd,
                         input int exp_k, input int exp_en, input string nm);
      int   n;
      int   en;
      int   busy;
      logic acc;
      logic done;
      exp_bus = '0;
      for (int i = 0; i < (1 << sz) && i < 4; i++) exp_bus[8*i +: 8] = wd[8*i +: 8];
      q.push_back(model(we, sz, sg, ad, wd, stub));
      cur_size = sz;
      @(posedge clk); #1;
      req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
      req_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (req_ready) acc = 1'b1;
      end
      chk({nm, "_accept"}, {31'd0, acc}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0; en = 0; busy = 0; done = 1'b0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
         if (ENABLE) en++;
         if (req_ready) busy++;
         if (rsp_valid) begin
            done = 1'b1;
            last_rdata = rsp_rdata;
         end
      end
      chk({nm, "_lat"}, 32'(n - 1), 32'(exp_k));
      chk({nm, "_en_cycles"}, 32'(en), 32'(exp_en));
      chk({nm, "_busy_ready"}, 32'(busy), 32'd0);
      @(negedge clk);
      if (we) begin
         chk({nm, "_turn"}, {29'd0, req_ready, ENABLE, READNOTWRITE}, 32'd1);
         @(negedge clk);
      end
      chk({nm, "_idle"}, {31'd0, req_ready}, 32'd1);
   endtask

   int acc2;
   int r0;
   logic seen_en;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]    = 8'h00;
         shadow[i] = 8'h00;
      end
      mem[16'h21] = 8'hF0;  shadow[16'h21] = 8'hF0;
      mem[16'h40] = 8'h01;  shadow[16'h40] = 8'h01;
      mem[16'h41] = 8'h80;  shadow[16'h41] = 8'h80;

      #12;
      chk("rst_enable", {31'd0, ENABLE}, 32'd0);
      chk("rst_rnw", {31'd0, READNOTWRITE}, 32'd1);
      chk("rst_addr", {16'd0, ADDRESS}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);

      do_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 2 + DELAY, DELAY + 1, "st_w");
      do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 2 + DELAY, DELAY + 1, "ld_w");
      chk("lit_word", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 2'b00, 1'b1, 16'h0021, 32'h0, 2 + DELAY, DELAY + 1, "ld_bs");
      chk("lit_byte_s", last_rdata, 32'hFFFFFFF0);
      do_req(1'b0, 2'b00, 1'b0, 16'h0021, 32'h0, 2 + DELAY, DELAY + 1, "ld_bu");
      chk("lit_byte_u", last_rdata, 32'h000000F0);

      do_req(1'b0, 2'b01, 1'b0, 16'h0003, 32'h0, 1, 0, "mis_h");
      do_req(1'b1, 2'b10, 1'b0, 16'h0002, 32'h12345678, 1, 0, "mis_w");
      do_req(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, 1, 0, "mis_sz3");

      do_req(1'b1, 2'b01, 1'b0, 16'h0050, 32'h1234ABCD, 2 + DELAY, DELAY + 1, "st_h");
      do_req(1'b0, 2'b10, 1'b0, 16'h0050, 32'h0, 2 + DELAY, DELAY + 1, "ld_w50");
      chk("lit_half_store", last_rdata, 32'h0000ABCD);
      do_req(1'b0, 2'b01, 1'b1, 16'h0040, 32'h0, 2 + DELAY, DELAY + 1, "ld_hs");
      chk("lit_half_s", last_rdata, 32'hFFFF8001);
      do_req(1'b1, 2'b00, 1'b0, 16'h0033, 32'hFFFFFF5A, 2 + DELAY, DELAY + 1, "st_b");
      do_req(1'b0, 2'b00, 1'b1, 16'h0033, 32'h0, 2 + DELAY, DELAY + 1, "ld_b33");
      chk("lit_byte_store", last_rdata, 32'h0000005A);

      stub = 1'b1;
      do_req(1'b0, 2'b10, 1'b0, 16'h0080, 32'h0, 1 + TO, TO, "tmo");

      // Reset while the store sits in WAIT with the bus driven.
      cur_size = 2'b10;
      exp_bus  = 32'h11223344;
      @(posedge clk); #1;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 16'h0060; req_wdata = 32'h11223344; req_valid = 1'b1;
      seen_en = 1'b0;
      for (int i = 0; i < 10 && !seen_en; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
         if (ENABLE) seen_en = 1'b1;
      end
      chk("rstw_reached_wait", {31'd0, seen_en}, 32'd1);
      r0 = nrsp;
      #2 rst = 1'b0;
      #1;
      chk("rstw_enable", {31'd0, ENABLE}, 32'd0);
      chk("rstw_rnw", {31'd0, READNOTWRITE}, 32'd1);
      chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b1;
      stub = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstw_no_rsp", 32'(nrsp - r0), 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 2 + DELAY, DELAY + 1, "post_rst");
      chk("lit_post_rst", last_rdata, 32'hDEADBEEF);

      // Back-to-back store then load with req_valid held high.
      r0 = nrsp;
      q.push_back(model(1'b1, 2'b10, 1'b0, 16'h0070, 32'hCAFEF00D, 1'b0));
      q.push_back(model(1'b0, 2'b10, 1'b0, 16'h0070, 32'h0, 1'b0));
      exp_bus  = 32'hCAFEF00D;
      cur_size = 2'b10;
      @(posedge clk); #1;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 16'h0070; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
      acc2 = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_valid && req_ready) begin
            acc2++;
            @(posedge clk); #1;
            if (acc2 == 1) req_we = 1'b0;
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(acc2), 32'd2);
      chk("b2b_rsps", 32'(nrsp - r0), 32'd2);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
